io_port_bank: RTL and testbench

- Parametrised memory-mapped I/O port bank for the single-cycle computer's data-memory I/O window.
- Generalises the fixed three-in/three-out port scheme to N_IN input and N_OUT output ports of DATA_W bits.
- Adds input synchronisers, sticky per-port change flags with write-1-to-clear, a maskable interrupt and a registered read path.
- Sits beside the data RAM; the dmem decoder drives io_sel for accesses to the I/O window.

---
 rtl/io_port_bank.sv | 145 ++++++++++++++
 tb/tb_io_port_bank.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/io_port_bank.sv
// Memory-mapped I/O port bank for the data-memory I/O window.
// Provides N_OUT writable output registers, N_IN synchronised input ports,
// sticky write-1-to-clear change flags, an interrupt mask and a registered
// read path. A short warm-up after reset hides the reset-to-live-value edge
// of the synchronisers so it never shows up as a change.
module io_port_bank #(
    parameter int                 DATA_W  = 32,
    parameter int                 N_IN    = 3,
    parameter int                 N_OUT   = 3,
    parameter logic [DATA_W-1:0]  OUT_RST = '0
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      io_sel,
    input  logic                      we,
    input  logic                      re,
    input  logic [7:0]                addr,
    input  logic [DATA_W-1:0]         wdata,
    output logic [DATA_W-1:0]         rdata,
    output logic                      rvalid,
    input  logic [N_IN*DATA_W-1:0]    in_ports,
    output logic [N_OUT*DATA_W-1:0]   out_ports,
    output logic                      irq
);

    localparam logic [5:0] IDX_IN   = 6'd16;
    localparam logic [5:0] IDX_CHG  = 6'd30;
    localparam logic [5:0] IDX_MASK = 6'd31;

    logic [DATA_W-1:0] out_r [N_OUT];
    logic [DATA_W-1:0] s1    [N_IN];
    logic [DATA_W-1:0] s2    [N_IN];
    logic [DATA_W-1:0] s3    [N_IN];
    logic [N_IN-1:0]   chg_r;
    logic [N_IN-1:0]   mask_r;
    logic [1:0]        warm_cnt;

    logic [5:0]        idx;
    logic              wr_en;
    logic              rd_en;
    logic [N_IN-1:0]   evt;
    logic [N_IN-1:0]   clr;
    logic [N_IN-1:0]   chg_next;
    logic [N_IN-1:0]   mask_next;
    logic [DATA_W-1:0] rd_mux;
    logic              addr_unused;

    // Byte offset bits carry no meaning for word-wide registers.
    assign addr_unused = ^addr[1:0];

    assign idx   = addr[7:2];
    assign wr_en = io_sel & we;
    assign rd_en = io_sel & re;

    // Change detection, flag set/clear (set wins) and next mask value.
    always_comb begin
        evt = '0;
        for (int i = 0; i < N_IN; i++) begin
            evt[i] = (s2[i] != s3[i]) && (warm_cnt == 2'd0);
        end
        clr       = (wr_en && idx == IDX_CHG) ? wdata[N_IN-1:0] : '0;
        chg_next  = (chg_r & ~clr) | evt;
        mask_next = (wr_en && idx == IDX_MASK) ? wdata[N_IN-1:0] : mask_r;
    end

    // Read mux over the pre-edge register values; unmapped indices read 0.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (idx == 6'(i)) rd_mux = out_r[i];
        end
        for (int i = 0; i < N_IN; i++) begin
            if (idx == IDX_IN + 6'(i)) rd_mux = s2[i];
        end
        if (idx == IDX_CHG)  rd_mux[N_IN-1:0] = chg_r;
        if (idx == IDX_MASK) rd_mux[N_IN-1:0] = mask_r;
    end

    // Two-flop synchroniser plus history stage for each input port.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N_IN; i++) begin
                s1[i] <= '0;
                s2[i] <= '0;
                s3[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                s1[i] <= in_ports[i*DATA_W +: DATA_W];
                s2[i] <= s1[i];
                s3[i] <= s2[i];
            end
        end
    end

    // Warm-up down-counter; change events are ignored until it reaches zero.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            warm_cnt <= 2'd3;
        end else if (warm_cnt != 2'd0) begin
            warm_cnt <= warm_cnt - 2'd1;
        end
    end

    // Output port registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N_OUT; i++) out_r[i] <= OUT_RST;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (wr_en && idx == 6'(i)) out_r[i] <= wdata;
            end
        end
    end

    // Change flags, interrupt mask and registered interrupt request.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            chg_r  <= '0;
            mask_r <= '0;
            irq    <= 1'b0;
        end else begin
            chg_r  <= chg_next;
            mask_r <= mask_next;
            irq    <= |(chg_next & mask_next);
        end
    end

    // Registered read data with a single-cycle valid pulse; rdata holds.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_en;
            if (rd_en) rdata <= rd_mux;
        end
    end

    // Pack the output registers onto the flat port bus.
    for (genvar g = 0; g < N_OUT; g++) begin : g_out
        assign out_ports[g*DATA_W +: DATA_W] = out_r[g];
    end

endmodule

// File: tb/tb_io_port_bank.sv
// Directed bench for io_port_bank with a read scoreboard: each read request
// pushes its hand-computed value, a monitor pops and compares on rvalid.
module tb_io_port_bank;

    localparam int DW = 32;
    localparam int NI = 3;
    localparam int NO = 3;

    logic              clock;
    logic              resetn;
    logic              io_sel;
    logic              we;
    logic              re;
    logic [7:0]        addr;
    logic [DW-1:0]     wdata;
    logic [DW-1:0]     rdata;
    logic              rvalid;
    logic [NI*DW-1:0]  in_ports;
    logic [NO*DW-1:0]  out_ports;
    logic              irq;

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] expq [$];

    io_port_bank #(.DATA_W(DW), .N_IN(NI), .N_OUT(NO), .OUT_RST('0)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .io_sel    (io_sel),
        .we        (we),
        .re        (re),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .in_ports  (in_ports),
        .out_ports (out_ports),
        .irq       (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle starting at a negedge; returns at the following negedge.
    task automatic access(input logic w, input logic r, input int idx,
                          input logic [DW-1:0] d, input logic [DW-1:0] exp);
        io_sel = 1'b1;
        we     = w;
        re     = r;
        addr   = 8'(idx << 2);
        wdata  = d;
        if (r) expq.push_back(exp);
        @(posedge clock);
        @(negedge clock);
        io_sel = 1'b0;
        we     = 1'b0;
        re     = 1'b0;
    endtask

    task automatic wr(input int idx, input logic [DW-1:0] d);
        access(1'b1, 1'b0, idx, d, '0);
    endtask

    task automatic rd(input int idx, input logic [DW-1:0] exp);
        access(1'b0, 1'b1, idx, '0, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Read monitor: every rvalid must match the oldest outstanding read.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rvalid === 1'b1) begin
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rvalid_unexpected: got rdata %h with no read outstanding", rdata);
                end else begin
                    chk("read_data", rdata, expq.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn   = 1'b0;
        io_sel   = 1'b0;
        we       = 1'b0;
        re       = 1'b0;
        addr     = '0;
        wdata    = '0;
        in_ports = {3{32'h5}};

        // Reset and warm-up.
        idle(3);
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        resetn = 1'b1;
        idle(1);
        rd(16, 32'h0);
        rd(16, 32'h5);
        idle(10);
        chk("rst_out_lo", out_ports[63:0], 64'h0);
        chk("rst_out_hi", out_ports[95:64], 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        rd(30, 32'h0);

        // Output write then read.
        wr(1, 32'hDEADBEEF);
        chk("out1_after_wr", out_ports[63:32], 32'hDEADBEEF);
        chk("out0_untouched", out_ports[31:0], 32'h0);
        rd(1, 32'hDEADBEEF);
        idle(1);

        // Change flag and interrupt on port 2.
        in_ports[95:64] = 32'h0;
        idle(6);
        wr(30, 32'h7);
        rd(30, 32'h0);
        wr(31, 32'h4);
        rd(31, 32'h4);
        in_ports[95:64] = 32'h1;
        idle(2);
        chk("irq_before_event", {31'b0, irq}, 32'd0);
        rd(30, 32'h0);
        rd(30, 32'h4);
        chk("irq_set", {31'b0, irq}, 32'd1);
        wr(30, 32'h4);
        idle(1);
        chk("irq_cleared", {31'b0, irq}, 32'd0);
        rd(30, 32'h0);

        // Set/clear collision on port 0: set must win.
        in_ports[31:0] = 32'h6;
        idle(2);
        wr(30, 32'h1);
        rd(30, 32'h1);
        chk("irq_unmasked_flag", {31'b0, irq}, 32'd0);
        wr(30, 32'h1);
        rd(30, 32'h0);

        // Simultaneous write and read to the same index.
        wr(0, 32'h11);
        access(1'b1, 1'b1, 0, 32'h22, 32'h11);
        rd(0, 32'h22);

        // Unmapped and unselected accesses.
        wr(20, 32'hFFFF);
        rd(20, 32'h0);
        io_sel = 1'b0; we = 1'b1; re = 1'b1; addr = 8'h00; wdata = 32'h99;
        @(posedge clock);
        @(negedge clock);
        we = 1'b0; re = 1'b0;
        chk("unsel_write", out_ports[31:0], 32'h22);
        rd(0, 32'h22);
        wr(31, 32'hFFFFFFFF);
        rd(31, 32'h7);

        // Reset asserted in the middle of traffic.
        wr(2, 32'h1234);
        in_ports[63:32] = 32'hA;
        idle(4);
        chk("irq_port1", {31'b0, irq}, 32'd1);
        rd(2, 32'h1234);
        io_sel = 1'b1; we = 1'b1; addr = 8'h08; wdata = 32'hABCD;
        #2;
        resetn = 1'b0;
        #1;
        chk("midrst_out", out_ports[95:64], 32'h0);
        chk("midrst_out1", out_ports[63:32], 32'h0);
        chk("midrst_irq", {31'b0, irq}, 32'd0);
        chk("midrst_rdata", rdata, 32'h0);
        @(posedge clock);
        #1;
        chk("midrst_hold", out_ports[95:64], 32'h0);
        @(negedge clock);
        io_sel = 1'b0; we = 1'b0;
        resetn = 1'b1;
        idle(5);
        rd(31, 32'h0);
        rd(30, 32'h0);
        idle(3);

        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL reads_outstanding: got %0d expected 0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
